// File: rtl/adc_scan_scheduler.sv
// Round-robin scan sequencer for an AD7991 behind an I2C controller: requests each
// enabled channel, validates the returned channel ID and latches samples per channel.
module adc_scan_scheduler #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [3:0]  CFG_LOW        = 4'b0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [3:0]  i_ch_mask,
    output logic [7:0]  o_cfg_byte,
    output logic        o_cfg_req,
    input  logic        i_cfg_ack,
    input  logic        i_rd_valid,
    input  logic [15:0] i_rd_data,
    output logic [11:0] o_ch0,
    output logic [11:0] o_ch1,
    output logic [11:0] o_ch2,
    output logic [11:0] o_ch3,
    output logic        o_upd_strobe,
    output logic [1:0]  o_upd_ch,
    output logic        o_timeout_err,
    output logic        o_id_err,
    output logic        o_busy
);

    localparam int unsigned MaxCnt = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                      : SETTLE_CYCLES;
    localparam int unsigned CntW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam logic [CntW-1:0] TmoLast    = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSelect, StReq, StWait, StCheck, StSettle} state_e;

    state_e           r_state, w_state;
    logic [CntW-1:0]  r_cnt, w_cnt;
    logic [1:0]       r_cur_ch, w_cur_ch;
    logic [13:0]      r_rd_data, w_rd_data;
    logic [3:0][11:0] r_ch, w_ch;
    logic [7:0]       r_cfg_byte, w_cfg_byte;
    logic             r_cfg_req, w_cfg_req;
    logic             r_upd_strobe, w_upd_strobe;
    logic [1:0]       r_upd_ch, w_upd_ch;
    logic             r_timeout_err, w_timeout_err;
    logic             r_id_err, w_id_err;
    logic             r_busy, w_busy;
    logic [1:0]       w_next_ch;
    logic [1:0]       w_unused_rd;

    assign w_unused_rd = i_rd_data[15:14];

    // First enabled channel strictly after cur, wrapping; lands on cur itself last.
    function automatic logic [1:0] f_next_ch(input logic [1:0] cur, input logic [3:0] mask);
        logic [1:0] idx;
        f_next_ch = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (mask[idx]) f_next_ch = idx;
        end
    endfunction

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_cur_ch      = r_cur_ch;
        w_rd_data     = r_rd_data;
        w_ch          = r_ch;
        w_cfg_byte    = r_cfg_byte;
        w_cfg_req     = r_cfg_req;
        w_upd_strobe  = 1'b0;
        w_upd_ch      = r_upd_ch;
        w_timeout_err = 1'b0;
        w_id_err      = 1'b0;
        w_next_ch     = f_next_ch(r_cur_ch, i_ch_mask);

        unique case (r_state)
            StIdle: begin
                if (i_run && (i_ch_mask != 4'b0000)) w_state = StSelect;
            end
            StSelect: begin
                if (i_ch_mask == 4'b0000) begin
                    w_state = StIdle;
                end else begin
                    w_cur_ch   = w_next_ch;
                    w_cfg_byte = {4'b0001 << w_next_ch, CFG_LOW};
                    w_cfg_req  = 1'b1;
                    w_state    = StReq;
                end
            end
            StReq: begin
                if (i_cfg_ack) begin
                    w_cfg_req = 1'b0;
                    w_cnt     = '0;
                    w_state   = StWait;
                end
            end
            StWait: begin
                // A result arriving on the last count still wins over the timeout.
                if (i_rd_valid) begin
                    w_rd_data = i_rd_data[13:0];
                    w_state   = StCheck;
                end else if (r_cnt == TmoLast) begin
                    w_timeout_err = 1'b1;
                    w_cnt         = '0;
                    w_state       = StSettle;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            StCheck: begin
                if (r_rd_data[13:12] == r_cur_ch) begin
                    w_ch[r_cur_ch] = r_rd_data[11:0];
                    w_upd_strobe   = 1'b1;
                    w_upd_ch       = r_cur_ch;
                end else begin
                    w_id_err = 1'b1;
                end
                w_cnt   = '0;
                w_state = StSettle;
            end
            StSettle: begin
                if (r_cnt == SettleLast) begin
                    w_state = i_run ? StSelect : StIdle;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase

        w_busy = (w_state != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_cur_ch      <= 2'd3;
            r_rd_data     <= '0;
            r_ch          <= '0;
            r_cfg_byte    <= 8'h00;
            r_cfg_req     <= 1'b0;
            r_upd_strobe  <= 1'b0;
            r_upd_ch      <= 2'd0;
            r_timeout_err <= 1'b0;
            r_id_err      <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_cur_ch      <= w_cur_ch;
            r_rd_data     <= w_rd_data;
            r_ch          <= w_ch;
            r_cfg_byte    <= w_cfg_byte;
            r_cfg_req     <= w_cfg_req;
            r_upd_strobe  <= w_upd_strobe;
            r_upd_ch      <= w_upd_ch;
            r_timeout_err <= w_timeout_err;
            r_id_err      <= w_id_err;
            r_busy        <= w_busy;
        end
    end

    assign o_cfg_byte    = r_cfg_byte;
    assign o_cfg_req     = r_cfg_req;
    assign o_ch0         = r_ch[0];
    assign o_ch1         = r_ch[1];
    assign o_ch2         = r_ch[2];
    assign o_ch3         = r_ch[3];
    assign o_upd_strobe  = r_upd_strobe;
    assign o_upd_ch      = r_upd_ch;
    assign o_timeout_err = r_timeout_err;
    assign o_id_err      = r_id_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized bench for adc_scan_scheduler: an I2C responder drives transactions while a
// round-robin model predicts the requested channel, result handling and latencies.
module tb_adc_scan_scheduler;

    localparam int unsigned SETTLE  = 5;
    localparam int unsigned TIMEOUT = 100;
    localparam logic [3:0]  CFG_LOW = 4'b0110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  ch_mask;
    logic [7:0]  cfg_byte;
    logic        cfg_req;
    logic        cfg_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [11:0] ch0, ch1, ch2, ch3;
    logic        upd_strobe;
    logic [1:0]  upd_ch;
    logic        timeout_err;
    logic        id_err;
    logic        busy;

    adc_scan_scheduler #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CFG_LOW       (CFG_LOW)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_run        (run),
        .i_ch_mask    (ch_mask),
        .o_cfg_byte   (cfg_byte),
        .o_cfg_req    (cfg_req),
        .i_cfg_ack    (cfg_ack),
        .i_rd_valid   (rd_valid),
        .i_rd_data    (rd_data),
        .o_ch0        (ch0),
        .o_ch1        (ch1),
        .o_ch2        (ch2),
        .o_ch3        (ch3),
        .o_upd_strobe (upd_strobe),
        .o_upd_ch     (upd_ch),
        .o_timeout_err(timeout_err),
        .o_id_err     (id_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state: last accepted sample per channel, current channel, applied mask.
    logic [11:0] m_ch [4];
    int          m_cur;
    logic [3:0]  m_mask;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_next(input int cur, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    function automatic logic [3:0] mask_for(input int i);
        if (i < 4) return 4'b1111;
        if (i < 8) return 4'b0101;
        if (i == 8) return 4'b1000;
        return 4'($urandom_range(1, 15));
    endfunction

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic check_chs();
        check_eq("ch0", 32'(ch0), 32'(m_ch[0]));
        check_eq("ch1", 32'(ch1), 32'(m_ch[1]));
        check_eq("ch2", 32'(ch2), 32'(m_ch[2]));
        check_eq("ch3", 32'(ch3), 32'(m_ch[3]));
    endtask

    // Counts falling edges until cfg_req is seen; bounded.
    task automatic wait_req(output int n);
        n = 0;
        while (!cfg_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got no cfg_req expected one within 60 cycles");
            finish_run();
        end
    endtask

    task automatic run_txn(input int i);
        int          n, a, d, mode;
        bit          drop;
        logic [3:0]  oh;
        logic [1:0]  id;
        logic [11:0] sample;

        m_cur = model_next(m_cur, m_mask);
        oh = 4'b0001 << m_cur;
        check_eq("cfg_byte", 32'(cfg_byte), 32'({oh, CFG_LOW}));
        check_eq("busy_req", 32'(busy), 32'd1);

        a = $urandom_range(0, 3);
        repeat (a) @(negedge clk);
        check_eq("req_hold", 32'(cfg_req), 32'd1);
        cfg_ack = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
            rd_valid = 1'b1;
            rd_data  = 16'($urandom);
        end
        @(negedge clk);
        cfg_ack  = 1'b0;
        rd_valid = 1'b0;
        check_eq("req_drop", 32'(cfg_req), 32'd0);

        m_mask  = mask_for(i);
        ch_mask = m_mask;
        drop = (i >= 10) && ($urandom_range(0, 5) == 0);
        if (drop) run = 1'b0;

        // 0: good result, 1: wrong channel ID, 2: no result
        mode = 0;
        if (i >= 10) begin
            n = $urandom_range(0, 99);
            mode = (n < 15) ? 2 : (n < 30) ? 1 : 0;
        end

        if (mode == 2) begin
            n = 0;
            while (!timeout_err && n < 200) begin
                @(negedge clk);
                n++;
            end
            check_eq("tmo_lat", 32'(n), 32'(TIMEOUT));
            check_eq("tmo_strobe", 32'(upd_strobe), 32'd0);
            check_eq("tmo_id_err", 32'(id_err), 32'd0);
            check_chs();
        end else begin
            d = ($urandom_range(0, 4) == 0) ? int'(TIMEOUT) - 1 : $urandom_range(0, 30);
            repeat (d) @(negedge clk);
            sample = 12'($urandom);
            id = (mode == 1) ? 2'((m_cur + $urandom_range(1, 3)) % 4) : 2'(m_cur);
            rd_valid = 1'b1;
            rd_data  = {2'($urandom), id, sample};
            @(negedge clk);
            rd_valid = 1'b0;
            check_eq("early_strobe", 32'(upd_strobe), 32'd0);
            check_eq("no_tmo", 32'(timeout_err), 32'd0);
            @(negedge clk);
            if (mode == 0) begin
                m_ch[m_cur] = sample;
                check_eq("upd_strobe", 32'(upd_strobe), 32'd1);
                check_eq("upd_ch", 32'(upd_ch), 32'(m_cur));
                check_eq("id_err", 32'(id_err), 32'd0);
            end else begin
                check_eq("bad_id_strobe", 32'(upd_strobe), 32'd0);
                check_eq("bad_id_err", 32'(id_err), 32'd1);
            end
            check_eq("res_tmo", 32'(timeout_err), 32'd0);
            check_chs();
        end

        if (drop) begin
            repeat (SETTLE - 1) @(negedge clk);
            check_eq("busy_settle", 32'(busy), 32'd1);
            @(negedge clk);
            check_eq("busy_idle", 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            check_eq("idle_req", 32'(cfg_req), 32'd0);
            run = 1'b1;
            wait_req(n);
            check_eq("resume_lat", 32'(n), 32'd2);
        end else begin
            wait_req(n);
            check_eq("period", 32'(n), 32'(SETTLE + 1));
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        run      = 1'b0;
        ch_mask  = 4'b0000;
        cfg_ack  = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 16'h0000;
        for (int k = 0; k < 4; k++) m_ch[k] = 12'h000;
        m_cur  = 3;
        m_mask = 4'b1111;

        repeat (3) @(negedge clk);
        check_eq("rst_cfg_req", 32'(cfg_req), 32'd0);
        check_eq("rst_cfg_byte", 32'(cfg_byte), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_strobe", 32'(upd_strobe), 32'd0);
        check_eq("rst_upd_ch", 32'(upd_ch), 32'd0);
        check_eq("rst_tmo", 32'(timeout_err), 32'd0);
        check_eq("rst_id_err", 32'(id_err), 32'd0);
        check_chs();

        ch_mask = m_mask;
        run     = 1'b1;
        rst_n   = 1'b1;
        wait_req(n);
        check_eq("start_lat", 32'(n), 32'd2);

        for (int i = 0; i < 60; i++) run_txn(i);

        // Reset while a request is pending must clear outputs without waiting for a clock.
        ch_mask = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_cfg_req", 32'(cfg_req), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_cfg_byte", 32'(cfg_byte), 32'd0);
        for (int k = 0; k < 4; k++) m_ch[k] = 12'h000;
        check_chs();
        @(negedge clk);
        m_cur  = 3;
        m_mask = 4'b1111;
        rst_n  = 1'b1;
        wait_req(n);
        check_eq("rerun_lat", 32'(n), 32'd2);
        check_eq("rerun_cfg_byte", 32'(cfg_byte), 32'({4'b0001, CFG_LOW}));

        finish_run();
    end

    initial begin
        #2ms;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        finish_run();
    end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Sequences the PmodAD2 (AD7991, 4-channel 12-bit I2C ADC) controller through a round-robin scan of enabled input channels. It writes the per-channel configuration byte, waits for the conversion result, checks the returned channel ID and latches each result into a per-channel holding register. It sits between the I2C controller and the display/channel-select logic on the 100 MHz system clock, and gives the display path stable, channel-tagged samples.

## Interface
Parameters:
- SETTLE_CYCLES, 1000: idle cycles between the end of one conversion and the next channel request (≥1).
- TIMEOUT_CYCLES, 2_000_000: maximum cycles in WAIT before a conversion is abandoned (≥2).
- CFG_LOW, 4'b0000: AD7991 config bits [3:0] (REF_SEL, FLTR, bit-trial delay, sample delay), sent unchanged on every request.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-low. All state and outputs clear while low.
- run  in  1  level; 1 = keep scanning.
- ch_mask  in  4  channel enable; bit i enables channel i.
- cfg_byte  out  8  config byte to the I2C controller: {one-hot channel[3:0], CFG_LOW}.
- cfg_req  out  1  request for the I2C controller to write cfg_byte and read one result.
- cfg_ack  in  1  one-cycle pulse: request accepted.
- rd_valid  in  1  one-cycle pulse: rd_data is valid.
- rd_data  in  16  AD7991 result word: [13:12] = channel ID, [11:0] = sample.
- ch0, ch1, ch2, ch3  out  12 each  last accepted sample for each channel.
- upd_strobe  out  1  one-cycle pulse when any chN is written.
- upd_ch  out  2  index of the channel written; valid with upd_strobe.
- timeout_err  out  1  one-cycle pulse when a conversion is abandoned.
- id_err  out  1  one-cycle pulse when the returned ID does not match the requested channel.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SELECT, REQ, WAIT, CHECK, SETTLE.
- IDLE: go to SELECT when run=1 and ch_mask≠0. Otherwise stay.
- SELECT (1 cycle): pick the next enabled channel after cur_ch, searching cyclically from cur_ch+1 mod 4. cur_ch resets to 3, so the first scan starts at channel 0 when it is enabled. If the mask is the single current channel, re-select that channel. Load cfg_byte, then go to REQ. If ch_mask=0 at this point, go to IDLE.
- REQ: hold cfg_req=1 and cfg_byte stable until cfg_ack. On the ack cycle, cfg_req drops on the next edge and the state moves to WAIT. There is no timeout in REQ.
- WAIT: count cycles from 0. If rd_valid arrives, capture rd_data and go to CHECK. If the count reaches TIMEOUT_CYCLES−1 with no rd_valid, pulse timeout_err and go to SETTLE. The channel register is left unchanged.
- CHECK (1 cycle): if rd_data[13:12]==cur_ch, write ch[cur_ch]←rd_data[11:0] and pulse upd_strobe with upd_ch=cur_ch. Otherwise pulse id_err and discard the sample. Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles. Then go to SELECT if run=1, or to IDLE if run=0.
- Changes to ch_mask are sampled only in SELECT. Registers of disabled channels hold their last value.
- If run drops in REQ, WAIT or CHECK, the current transaction completes and the block enters IDLE after SETTLE. cfg_req is never withdrawn before ack.
- rd_valid outside WAIT is ignored.

## Timing
- Reset values: cfg_req=0, cfg_byte=8'h00, ch0–ch3=0, upd_strobe=0, upd_ch=0, timeout_err=0, id_err=0, busy=0, state=IDLE, cur_ch=3.
- All outputs are registered.
- IDLE→cfg_req high: 2 edges (IDLE→SELECT, SELECT→REQ).
- rd_valid at edge t: chN and upd_strobe are valid after edge t+2 (capture, then CHECK).
- Channel period = handshake time + conversion time + 3 + SETTLE_CYCLES.
- cfg_ack and rd_valid in the same cycle while in REQ: the ack is taken, and rd_valid is ignored.
- rd_valid in the same cycle as the timeout count: rd_valid wins, and no timeout_err is raised.
- Reset asserted mid-transaction: cfg_req clears immediately (asynchronously). After release, the scan restarts from channel 0.

## Test plan
- Reset, run=1, mask=4'b1111, ideal I2C model (ack 3 cycles after req, rd_valid 50 cycles after ack, correct ID) → cfg_byte sequence 8'h10, 8'h20, 8'h40, 8'h80, 8'h10. upd_ch goes 0,1,2,3,0. chN equals the sample the model drove.
- mask=4'b0101 → only channels 0 and 2 are requested, alternating. ch1 and ch3 stay 0. Changing the mask to 4'b1000 mid-WAIT takes effect at the next SELECT.
- Model never returns rd_valid, TIMEOUT_CYCLES=100 → timeout_err pulses 100 cycles after ack, the channel register is unchanged, and the scan advances to the next channel.
- Model returns ID 2'b11 while channel 1 is requested → id_err pulses once, ch1 is unchanged, and no upd_strobe is issued.
- Drop run during WAIT → the result is still latched, then busy=0 after SETTLE. Reassert run → the scan resumes at the next channel.
- Assert rst low during REQ → cfg_req and all outputs are 0 immediately. After release, the first cfg_byte is 8'h10.
